// File: rtl/e203_nice_csr_arb_if.sv
// -----------------------------------------------------------------------------
// e203_nice_csr_arb_if
//   Bus bundle for the NICE extended-CSR arbiter: two requester channels
//   (req0 = core CSR path, req1 = debug/secondary master) and the single
//   NICE extended-CSR target channel.
//
//   Modports:
//     master : arbiter view (accepts requester channels, drives the target)
//     slave  : environment view (requesters and target model)
//
//   Signals per requester N (N = 0,1):
//     reqN_valid  access request          reqN_ready  completion strobe (1 cycle)
//     reqN_addr   CSR address             reqN_wr     write (1) / read (0)
//     reqN_wdata  write data              reqN_rdata  read data, valid with ready
//     reqN_err    timeout abort, valid with ready
//   Target channel:
//     nice_csr_valid/addr/wr/wdata  latched request towards the target
//     nice_csr_ready/rdata          target accept/complete and read data
// -----------------------------------------------------------------------------
interface e203_nice_csr_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic              req0_wr;
   logic [DATA_W-1:0] req0_wdata;
   logic [DATA_W-1:0] req0_rdata;
   logic              req0_err;

   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic              req1_wr;
   logic [DATA_W-1:0] req1_wdata;
   logic [DATA_W-1:0] req1_rdata;
   logic              req1_err;

   logic              nice_csr_valid;
   logic              nice_csr_ready;
   logic [ADDR_W-1:0] nice_csr_addr;
   logic              nice_csr_wr;
   logic [DATA_W-1:0] nice_csr_wdata;
   logic [DATA_W-1:0] nice_csr_rdata;

   modport master (
      input  req0_valid, req0_addr, req0_wr, req0_wdata,
      output req0_ready, req0_rdata, req0_err,
      input  req1_valid, req1_addr, req1_wr, req1_wdata,
      output req1_ready, req1_rdata, req1_err,
      output nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
      input  nice_csr_ready, nice_csr_rdata
   );

   modport slave (
      output req0_valid, req0_addr, req0_wr, req0_wdata,
      input  req0_ready, req0_rdata, req0_err,
      output req1_valid, req1_addr, req1_wr, req1_wdata,
      input  req1_ready, req1_rdata, req1_err,
      input  nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
      output nice_csr_ready, nice_csr_rdata
   );
endinterface

// File: rtl/e203_nice_csr_arb.sv
// -----------------------------------------------------------------------------
// e203_nice_csr_arb
//   Round-robin arbiter sharing the NICE extended-CSR target between the core
//   CSR path (requester 0) and a debug/secondary master (requester 1).
//   One transaction in flight; target fields are latched at grant and held
//   stable while BUSY. A bounded wait aborts hung target accesses.
//
//   Ports:
//     clk        core clock
//     rst        synchronous active-high reset
//     bus        requester/target bundle (master modport)
//     arb_busy   high whenever the arbiter is not IDLE
//     tmo_pulse  one-cycle pulse in the BUSY cycle that aborts on timeout
//
//   Parameters:
//     ADDR_W/DATA_W  CSR address/data widths
//     TMO_CYC        max target wait cycles before abort (0 disables timeout)
//     CNT_W          wait-counter width, 2**CNT_W > TMO_CYC
// -----------------------------------------------------------------------------
module e203_nice_csr_arb #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 16,
   parameter int CNT_W   = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   e203_nice_csr_arb_if.master    bus,
   output logic                   arb_busy,
   output logic                   tmo_pulse
);

   localparam bit             TMO_EN   = (TMO_CYC != 0);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC != 0) ? TMO_CYC - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              gnt_id_q, gnt_id_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              gnt_sel;
   logic              tmo_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= 1'b0;
         gnt_id_q   <= 1'b0;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_id_q   <= gnt_id_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_id_d   = gnt_id_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      gnt_sel    = 1'b0;
      tmo_hit    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               // Contention resolved by rr_ptr; a lone requester always wins.
               gnt_sel    = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
               gnt_id_d   = gnt_sel;
               addr_d     = gnt_sel ? bus.req1_addr  : bus.req0_addr;
               wr_d       = gnt_sel ? bus.req1_wr    : bus.req0_wr;
               wdata_d    = gnt_sel ? bus.req1_wdata : bus.req0_wdata;
               rdata_d    = '0;
               err_d      = 1'b0;
               wait_cnt_d = '0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // Target ready takes precedence over a coincident timeout.
            if (bus.nice_csr_ready) begin
               rdata_d = wr_q ? '0 : bus.nice_csr_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (TMO_EN && (wait_cnt_q == TMO_LAST)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               tmo_hit = 1'b1;
               state_d = RESP;
            end else if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         RESP: begin
            rr_ptr_d = ~gnt_id_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.nice_csr_valid = (state_q == BUSY);
   assign bus.nice_csr_addr  = addr_q;
   assign bus.nice_csr_wr    = wr_q;
   assign bus.nice_csr_wdata = wdata_q;

   assign bus.req0_ready = (state_q == RESP) && !gnt_id_q;
   assign bus.req1_ready = (state_q == RESP) &&  gnt_id_q;
   assign bus.req0_rdata = bus.req0_ready ? rdata_q : '0;
   assign bus.req1_rdata = bus.req1_ready ? rdata_q : '0;
   assign bus.req0_err   = bus.req0_ready & err_q;
   assign bus.req1_err   = bus.req1_ready & err_q;

   assign arb_busy  = (state_q != IDLE);
   assign tmo_pulse = tmo_hit;

endmodule

// File: tb/tb_e203_nice_csr_arb.sv
// -----------------------------------------------------------------------------
// tb_e203_nice_csr_arb
//   Scoreboard bench for e203_nice_csr_arb. Requester drivers push the
//   expected response per requester when a request is raised; a monitor pops
//   and compares on every ready pulse. A target model answers after a delay
//   derived from the address (or a directed override).
// -----------------------------------------------------------------------------
module tb_e203_nice_csr_arb;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;
   localparam int CW  = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic arb_busy;
   logic tmo_pulse;

   e203_nice_csr_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   e203_nice_csr_arb #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .arb_busy  (arb_busy),
      .tmo_pulse (tmo_pulse)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   int          log_id[$];
   int unsigned log_cyc[$];
   bit          log_en = 1'b0;

   bit          ovr_en    = 1'b0;
   int          ovr_delay = 0;
   logic [31:0] ovr_rdata = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference rules: target answers after delay_of() wait cycles (0 = first
   // BUSY cycle); an access whose answer would come after TMO BUSY cycles is
   // aborted with err=1, rdata=0; writes always return rdata=0.
   function automatic int delay_of(input logic [31:0] a);
      return ovr_en ? ovr_delay : int'(a % 32'd20);
   endfunction

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return ovr_en ? ovr_rdata : ((a * 32'h9E3779B1) ^ 32'hC3C3_0000);
   endfunction

   function automatic logic [32:0] expected(input logic [31:0] a, input logic w);
      bit err;
      err = (TMO != 0) && (delay_of(a) >= TMO);
      return {err, (err || w) ? 32'h0 : rdata_of(a)};
   endfunction

   task automatic push(input int id, input logic [31:0] a, input logic w);
      if (id == 0) exp_q0.push_back(expected(a, w));
      else         exp_q1.push_back(expected(a, w));
   endtask

   task automatic set_req(input int id, input logic v, input logic [31:0] a,
                          input logic w, input logic [31:0] d);
      if (id == 0) begin
         bus.req0_valid = v; bus.req0_addr = a; bus.req0_wr = w; bus.req0_wdata = d;
      end else begin
         bus.req1_valid = v; bus.req1_addr = a; bus.req1_wr = w; bus.req1_wdata = d;
      end
   endtask

   function automatic logic rdy(input int id);
      return (id == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Requester driver: n requests with random idle gaps, each held until ready.
   task automatic drive(input int id, input int n, input int max_gap, input bit rnd);
      logic [31:0] a, d;
      logic        w;
      int          g, k;
      bit          got;
      for (int i = 0; i < n; i++) begin
         if (max_gap > 0) begin
            g = $urandom_range(max_gap, 0);
            if (g > 0) begin
               set_req(id, 1'b0, '0, 1'b0, '0);
               repeat (g) step();
            end
         end
         a = rnd ? $urandom : ((id == 0) ? 32'h0000_0700 : 32'h0000_0300) + 32'(i);
         w = rnd ? 1'($urandom % 2) : 1'b0;
         d = $urandom;
         push(id, a, w);
         set_req(id, 1'b1, a, w, d);
         k   = 0;
         got = 1'b0;
         while (!got && k < 64) begin
            smp();
            got = rdy(id);
            k++;
         end
         if (!got) check($sformatf("req%0d ready within bound", id), 64'd0, 64'd1);
         step();
      end
      set_req(id, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic mon(input int id, input logic r, input logic [31:0] rd, input logic e);
      logic [32:0] x;
      if (r) begin
         if ((id == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
            check($sformatf("req%0d unexpected ready", id), 64'd1, 64'd0);
         end else begin
            x = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("req%0d rdata", id), 64'(rd), 64'(x[31:0]));
            check($sformatf("req%0d err", id), 64'(e), 64'(x[32]));
         end
         if (log_en) begin
            log_id.push_back(id);
            log_cyc.push_back(cyc);
         end
      end else begin
         check($sformatf("req%0d rdata/err idle", id), 64'({e, rd}), 64'd0);
      end
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         mon(0, bus.req0_ready, bus.req0_rdata, bus.req0_err);
         mon(1, bus.req1_ready, bus.req1_rdata, bus.req1_err);
         if (bus.req0_ready && bus.req1_ready) check("both ready", 64'd1, 64'd0);
      end
   end

   // Target model: checks fields stay stable through BUSY, answers after the
   // chosen delay, and fires one stray late ready after an abandoned access.
   initial begin
      int          cnt = 0;
      int          cur_delay = 0;
      logic [31:0] cap_a, cap_d;
      logic        cap_w;
      bus.nice_csr_ready = 1'b0;
      bus.nice_csr_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.nice_csr_ready = 1'b0;
         bus.nice_csr_rdata = '0;
         if (bus.nice_csr_valid) begin
            if (cnt == 0) begin
               cap_a     = bus.nice_csr_addr;
               cap_w     = bus.nice_csr_wr;
               cap_d     = bus.nice_csr_wdata;
               cur_delay = delay_of(cap_a);
            end else begin
               check("tgt addr stable", 64'(bus.nice_csr_addr), 64'(cap_a));
               check("tgt wr stable", 64'(bus.nice_csr_wr), 64'(cap_w));
               check("tgt wdata stable", 64'(bus.nice_csr_wdata), 64'(cap_d));
            end
            if (cnt == cur_delay) begin
               bus.nice_csr_ready = 1'b1;
               bus.nice_csr_rdata = rdata_of(cap_a);
               cnt = 0;
            end else begin
               cnt++;
            end
         end else if (cnt != 0) begin
            bus.nice_csr_ready = 1'b1;
            bus.nice_csr_rdata = 32'hBAD0_BAD0;
            cnt = 0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      set_req(0, 1'b0, '0, 1'b0, '0);
      set_req(1, 1'b0, '0, 1'b0, '0);
      rst = 1'b1;
      repeat (3) step();
      smp();
      check("reset nice_csr_valid", 64'(bus.nice_csr_valid), 64'd0);
      check("reset arb_busy", 64'(arb_busy), 64'd0);
      check("reset tmo_pulse", 64'(tmo_pulse), 64'd0);
      check("reset req0_ready", 64'(bus.req0_ready), 64'd0);
      check("reset req1_ready", 64'(bus.req1_ready), 64'd0);

      // Contention from reset, target always ready: grants 0,1,0,1, 3 cycles apart.
      ovr_en = 1'b1; ovr_delay = 0; ovr_rdata = 32'h0000_1111;
      log_en = 1'b1;
      step();
      rst = 1'b0;
      fork
         drive(0, 4, 0, 1'b0);
         drive(1, 4, 0, 1'b0);
      join
      log_en = 1'b0;
      check("contention grant count", 64'(log_id.size()), 64'd8);
      for (int i = 0; i < log_id.size(); i++) begin
         check($sformatf("contention grant %0d id", i), 64'(log_id[i]), 64'(i % 2));
         if (i > 0) check($sformatf("contention spacing %0d", i),
                          64'(log_cyc[i] - log_cyc[i-1]), 64'd3);
      end

      // Single read, minimum latency.
      step();
      ovr_delay = 0; ovr_rdata = 32'hDEAD_BEEF;
      set_req(0, 1'b1, 32'h7C0, 1'b0, '0);
      push(0, 32'h7C0, 1'b0);
      smp();
      check("t1 valid at T", 64'(bus.nice_csr_valid), 64'd0);
      step(); smp();
      check("t1 valid at T+1", 64'(bus.nice_csr_valid), 64'd1);
      check("t1 addr at T+1", 64'(bus.nice_csr_addr), 64'h7C0);
      check("t1 ready at T+1", 64'(bus.req0_ready), 64'd0);
      step(); smp();
      check("t1 ready at T+2", 64'(bus.req0_ready), 64'd1);
      check("t1 rdata at T+2", 64'(bus.req0_rdata), 64'hDEAD_BEEF);
      step();
      set_req(0, 1'b0, '0, 1'b0, '0);
      smp();
      check("t1 ready at T+3", 64'(bus.req0_ready), 64'd0);

      // Write with slow target: wdata held for all 6 BUSY cycles, rdata forced 0.
      step();
      ovr_delay = 5; ovr_rdata = 32'hFFFF_FFFF;
      set_req(1, 1'b1, 32'h7C1, 1'b1, 32'h1234_5678);
      push(1, 32'h7C1, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         step(); smp();
         check($sformatf("t3 valid busy %0d", k), 64'(bus.nice_csr_valid), 64'd1);
         check($sformatf("t3 wdata busy %0d", k), 64'(bus.nice_csr_wdata), 64'h1234_5678);
         check($sformatf("t3 ready busy %0d", k), 64'(bus.req1_ready), 64'd0);
      end
      step(); smp();
      check("t3 req1_ready", 64'(bus.req1_ready), 64'd1);
      check("t3 req1_rdata", 64'(bus.req1_rdata), 64'd0);
      step();
      set_req(1, 1'b0, '0, 1'b0, '0);

      // Timeout: target never answers in time, late ready ignored.
      step();
      ovr_delay = 100; ovr_rdata = 32'h0000_0011;
      set_req(0, 1'b1, 32'h7C2, 1'b0, '0);
      push(0, 32'h7C2, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         step(); smp();
         check($sformatf("t4 valid busy %0d", k), 64'(bus.nice_csr_valid), 64'd1);
         check($sformatf("t4 tmo_pulse busy %0d", k), 64'(tmo_pulse), 64'(k == 16));
      end
      step(); smp();
      check("t4 req0_ready", 64'(bus.req0_ready), 64'd1);
      check("t4 req0_err", 64'(bus.req0_err), 64'd1);
      check("t4 tmo_pulse after", 64'(tmo_pulse), 64'd0);
      step();
      set_req(0, 1'b0, '0, 1'b0, '0);
      smp();
      check("t4 idle after", 64'(arb_busy), 64'd0);
      step(); smp();
      check("t4 late ready ignored", 64'(arb_busy), 64'd0);

      // Ready and timeout in the same cycle: ready wins.
      step();
      ovr_delay = 15; ovr_rdata = 32'hA5A5_A5A5;
      set_req(0, 1'b1, 32'h7C3, 1'b0, '0);
      push(0, 32'h7C3, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         step(); smp();
         check($sformatf("t5 tmo_pulse busy %0d", k), 64'(tmo_pulse), 64'd0);
      end
      step(); smp();
      check("t5 req0_ready", 64'(bus.req0_ready), 64'd1);
      check("t5 req0_rdata", 64'(bus.req0_rdata), 64'hA5A5_A5A5);
      check("t5 req0_err", 64'(bus.req0_err), 64'd0);
      step();
      set_req(0, 1'b0, '0, 1'b0, '0);

      // Reset in the 3rd BUSY cycle: silent drop, priority back to requester 0.
      step();
      ovr_delay = 50;
      set_req(0, 1'b1, 32'h7C4, 1'b0, '0);
      step(); step(); step();
      rst = 1'b1;
      smp();
      check("t6 busy before reset edge", 64'(arb_busy), 64'd1);
      step();
      rst = 1'b0;
      set_req(0, 1'b0, '0, 1'b0, '0);
      smp();
      check("t6 valid after reset", 64'(bus.nice_csr_valid), 64'd0);
      check("t6 busy after reset", 64'(arb_busy), 64'd0);
      check("t6 no ready after reset", 64'(bus.req0_ready), 64'd0);
      repeat (2) step();
      smp();
      check("t6 still idle", 64'(arb_busy), 64'd0);
      ovr_delay = 0; ovr_rdata = 32'h0000_2222;
      log_id.delete();
      log_cyc.delete();
      log_en = 1'b1;
      step();
      fork
         drive(0, 1, 0, 1'b0);
         drive(1, 1, 0, 1'b0);
      join
      log_en = 1'b0;
      check("t6 grants after reset", 64'(log_id.size()), 64'd2);
      if (log_id.size() == 2) begin
         check("t6 first grant", 64'(log_id[0]), 64'd0);
         check("t6 second grant", 64'(log_id[1]), 64'd1);
      end

      // Randomized traffic against the reference rules.
      ovr_en = 1'b0;
      step();
      fork
         drive(0, 40, 3, 1'b1);
         drive(1, 40, 3, 1'b1);
      join
      repeat (4) step();
      smp();
      check("scoreboard q0 drained", 64'(exp_q0.size()), 64'd0);
      check("scoreboard q1 drained", 64'(exp_q1.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/e203_nice_csr_arb.md
Name: e203_nice_csr_arb

Overview:
- Shares the single NICE extended-CSR target port (valid/ready, addr/wr/wdata/rdata) between two requesters.
  - Requester 0: core CSR execution path.
  - Requester 1: debug/secondary master.
- Round-robin arbitration, one outstanding transaction at a time.
- Target fields are latched and held stable while the target is busy.
- A bounded-wait timeout aborts hung accesses.
- Sits between the requesters and the extended-CSR target in the core.

Parameters:
- ADDR_W, 32, CSR address width.
- DATA_W, 32, CSR data width.
- TMO_CYC, 16, max target wait cycles before abort (0 = timeout disabled).
- CNT_W, 5, wait-counter width; must satisfy 2^CNT_W > TMO_CYC.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 access request
- req0_ready  out  1  requester 0 completion strobe (1 cycle)
- req0_addr  in  ADDR_W  requester 0 CSR address
- req0_wr  in  1  requester 0 write (1) / read (0)
- req0_wdata  in  DATA_W  requester 0 write data
- req0_rdata  out  DATA_W  requester 0 read data, valid with req0_ready
- req0_err  out  1  requester 0 timeout abort, valid with req0_ready
- req1_valid, req1_ready, req1_addr, req1_wr, req1_wdata, req1_rdata, req1_err: as requester 0, for requester 1
- nice_csr_valid  out  1  target request
- nice_csr_ready  in  1  target accept/complete
- nice_csr_addr  out  ADDR_W  latched address
- nice_csr_wr  out  1  latched write flag
- nice_csr_wdata  out  DATA_W  latched write data
- nice_csr_rdata  in  DATA_W  target read data, valid with nice_csr_ready
- arb_busy  out  1  state != IDLE
- tmo_pulse  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State = IDLE; rr_ptr = 0 (requester 0 has priority); wait_cnt = 0.
  - Latched addr/wr/wdata/rdata/err/gnt_id = 0.
  - All outputs 0: nice_csr_valid, reqN_ready, reqN_err, reqN_rdata, arb_busy, tmo_pulse.
  - Reset mid-transaction: the transaction is dropped silently and no requester sees ready.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any reqN_valid=1, grant:
    - Both valid: the requester indexed by rr_ptr wins.
    - Only one valid: that one wins.
  - Latch its addr/wr/wdata and gnt_id; clear wait_cnt; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - nice_csr_valid=1; nice_csr_addr/wr/wdata driven from the latched fields, stable throughout.
  - nice_csr_ready=1: latch nice_csr_rdata (forced to 0 when the latched wr=1); err=0; go to RESP.
  - Else, TMO_CYC != 0 and wait_cnt == TMO_CYC-1: latched rdata=0, err=1, tmo_pulse=1 for this cycle; go to RESP.
  - Else wait_cnt+1, saturating at its maximum when TMO_CYC=0.
  - If ready and timeout coincide, ready wins: no error.
- RESP:
  - Granted requester sees reqN_ready=1 for exactly one cycle, with reqN_rdata/reqN_err from the latches.
  - Non-granted requester sees ready=0, rdata=0, err=0.
  - rr_ptr = ~gnt_id; go to IDLE.
  - reqN_rdata/err are 0 whenever the matching ready=0.
- Latency: request sampled in IDLE at cycle T; nice_csr_valid=1 at T+1.
  - Target ready at T+1 gives requester ready at T+2, which is the minimum.
  - Back-to-back: the next grant happens in the IDLE cycle after RESP, so a 3-cycle minimum period per transaction.
- Requester protocol:
  - reqN_valid and its fields must stay stable until reqN_ready.
  - Fields are latched at grant, so later changes are ignored.
  - If valid drops early, the transaction still completes and the ready pulse is still issued.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Target protocol: nice_csr_valid is never deasserted in BUSY before ready or timeout. A late target ready arriving after an abort, while the arbiter is in RESP/IDLE, is ignored.
- arb_busy = (state != IDLE).

Test Plan:
1. Single read: req0 addr=0x7C0, target ready on its first valid cycle with rdata=0xDEADBEEF -> nice_csr_addr=0x7C0 at T+1; req0_ready=1, rdata=0xDEADBEEF, err=0 at T+2 only.
2. Contention: req0 and req1 held valid from reset, target always ready -> grant order 0,1,0,1; each ready pulse 3 cycles apart; the other requester's ready/rdata stay 0.
3. Write with slow target: req1 wr=1, wdata=0x12345678, target ready after 5 wait cycles -> nice_csr_wdata held at 0x12345678 for all 6 BUSY cycles; req1_ready with rdata=0, err=0.
4. Timeout: TMO_CYC=16, target never ready -> tmo_pulse in the 16th BUSY cycle; req0_ready=1, err=1, rdata=0 next cycle; a later target ready is ignored.
5. Ready/timeout tie: target ready exactly in the 16th BUSY cycle with rdata=0xA5A5A5A5 -> err=0, rdata=0xA5A5A5A5, no tmo_pulse.
6. Reset mid-BUSY: rst=1 for one cycle in the 3rd BUSY cycle -> next cycle nice_csr_valid=0, arb_busy=0, no ready pulse; requester 0 wins the next contention.
